// File: rtl/uart_alu_if.sv
// Byte/ALU/TX signal bundle between the UART side, the ALU and the frame sequencer.
interface uart_alu_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_RES;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_A;
  logic [NB_DATA-1:0] o_data_B;
  logic [NB_OP-1:0]   o_OP;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_RES, i_tx_done,
    output o_data_A, o_data_B, o_OP, o_tx_data, o_tx_start, o_busy, o_timeout
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_RES, i_tx_done,
    input  o_data_A, o_data_B, o_OP, o_tx_data, o_tx_start, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Frame sequencer: collects A, B, opcode bytes from UART rx, holds them on the ALU,
// captures the result and hands it to UART tx; aborts stalled partial frames.
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  uart_alu_if.slave  bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {ST_A, ST_B, ST_OP, ST_RES, ST_TX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_q, timeout_d;
  logic               expire;

  // A byte arriving on the expiry cycle wins over the abort.
  assign expire = (TIMEOUT_CYCLES > 0) && ((state_q == ST_B) || (state_q == ST_OP)) &&
                  !bus.i_rx_done && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_A: begin
        if (bus.i_rx_done) begin
          data_a_d = bus.i_rx_data;
          cnt_d    = '0;
          state_d  = ST_B;
        end
      end
      ST_B, ST_OP: begin
        if (bus.i_rx_done) begin
          cnt_d = '0;
          if (state_q == ST_B) begin
            data_b_d = bus.i_rx_data;
            state_d  = ST_OP;
          end else begin
            op_d    = bus.i_rx_data[NB_OP-1:0];
            state_d = ST_RES;
          end
        end else if (expire) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_A;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RES: begin
        tx_data_d  = bus.i_alu_RES;
        tx_start_d = 1'b1;
        state_d    = ST_TX;
      end
      ST_TX: begin
        if (bus.i_tx_done) state_d = ST_A;
      end
      default: state_d = ST_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_A;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.o_data_A   = data_a_q;
  assign bus.o_data_B   = data_b_q;
  assign bus.o_OP       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_busy     = (state_q == ST_RES) || (state_q == ST_TX);
endmodule

// File: tb/tb_uart_alu_interface.sv
// Randomized frame traffic against a frame-level reference of the sequencer.
module tb_uart_alu_interface;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) ifc();

  uart_alu_interface #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifc)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'(sa >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // Combinational ALU stage sitting behind the sequencer.
  assign ifc.i_alu_RES = alu_ref(ifc.o_data_A, ifc.o_data_B, ifc.o_OP);

  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_to = 0;

  always @(posedge clk) begin
    if (ifc.o_tx_start) n_start <= n_start + 1;
    if (ifc.o_timeout)  n_to    <= n_to + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ifc.i_rx_data = b;
    ifc.i_rx_done = 1'b1;
    @(negedge clk);
    ifc.i_rx_done = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},   32'(ifc.o_data_A), 0);
    chk({tag, "_b"},   32'(ifc.o_data_B), 0);
    chk({tag, "_op"},  32'(ifc.o_OP), 0);
    chk({tag, "_txd"}, 32'(ifc.o_tx_data), 0);
    chk({tag, "_st"},  32'(ifc.o_tx_start), 0);
    chk({tag, "_bsy"}, 32'(ifc.o_busy), 0);
    chk({tag, "_to"},  32'(ifc.o_timeout), 0);
  endtask

  // Full frame with the given inter-byte gaps (<= TO-1 idle edges never expire).
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int ga, input int gb, input bit drop);
    logic [7:0] exp;
    int s0, t0;
    exp = alu_ref(a, b, opb[5:0]);
    s0 = n_start;
    t0 = n_to;
    send_byte(a);
    idle(ga);
    send_byte(b);
    idle(gb);
    send_byte(opb);
    chk("busy_res", 32'(ifc.o_busy), 1);
    chk("start_early", 32'(ifc.o_tx_start), 0);
    @(negedge clk);
    chk("start", 32'(ifc.o_tx_start), 1);
    chk("tx_data", 32'(ifc.o_tx_data), 32'(exp));
    chk("op_out", 32'(ifc.o_OP), 32'(opb[5:0]));
    chk("a_out", 32'(ifc.o_data_A), 32'(a));
    chk("b_out", 32'(ifc.o_data_B), 32'(b));
    @(negedge clk);
    chk("start_pulse", 32'(ifc.o_tx_start), 0);
    chk("n_start", 32'(n_start), 32'(s0 + 1));
    if (drop) begin
      send_byte(8'h55);
      chk("drop_busy", 32'(ifc.o_busy), 1);
      chk("drop_a", 32'(ifc.o_data_A), 32'(a));
    end
    idle($urandom_range(0, 3));
    ifc.i_tx_done = 1'b1;
    @(negedge clk);
    ifc.i_tx_done = 1'b0;
    chk("busy_idle", 32'(ifc.o_busy), 0);
    chk("tx_hold", 32'(ifc.o_tx_data), 32'(exp));
    chk("no_to", 32'(n_to), 32'(t0));
  endtask

  // Partial frame (1 or 2 bytes) left to stall for TO idle edges plus extra.
  task automatic abort_frame(input int nbytes, input int extra);
    int s0, t0;
    s0 = n_start;
    t0 = n_to;
    send_byte(8'($urandom));
    if (nbytes == 2) send_byte(8'($urandom));
    idle(TO - 1);
    chk("to_early", 32'(ifc.o_timeout), 0);
    idle(1);
    chk("timeout", 32'(ifc.o_timeout), 1);
    chk("busy_to", 32'(ifc.o_busy), 0);
    idle(1);
    chk("to_pulse", 32'(ifc.o_timeout), 0);
    idle(extra);
    chk("n_to", 32'(n_to), 32'(t0 + 1));
    chk("to_nostart", 32'(n_start), 32'(s0));
  endtask

  task automatic reset_mid(input bit in_tx);
    int s0;
    s0 = n_start;
    send_byte(8'h77);
    send_byte(8'h66);
    if (in_tx) begin
      send_byte(8'h20);
      idle(2);
    end
    s0 = n_start;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("rst_nostart", 32'(n_start), 32'(s0));
  endtask

  logic [7:0] op_tbl [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  initial begin
    ifc.i_rx_data = '0;
    ifc.i_rx_done = 1'b0;
    ifc.i_tx_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 1'b0);
    run_frame(8'hF0, 8'h02, 8'h03, 1, 2, 1'b0);
    run_frame(8'h0F, 8'hF0, 8'h27, 0, 3, 1'b0);
    abort_frame(1, 0);
    run_frame(8'h01, 8'h01, 8'h22, 0, 0, 1'b0);
    abort_frame(2, 2);
    run_frame(8'h09, 8'h07, 8'h26, 0, 0, 1'b1);
    run_frame(8'h02, 8'h04, 8'h25, 0, 0, 1'b0);
    reset_mid(1'b0);
    run_frame(8'h0C, 8'h0A, 8'h24, 0, 0, 1'b0);
    run_frame(8'h3C, 8'h5A, 8'h3F, TO - 1, TO - 1, 1'b0);
    run_frame(8'h12, 8'h34, 8'hE0, 2, 0, 1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] opb;
      opb = op_tbl[$urandom_range(0, 7)] | 8'({$urandom_range(0, 3), 6'h00});
      if ($urandom_range(0, 4) == 0) opb = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1, 2: run_frame(8'($urandom), 8'($urandom), opb,
                           $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 1'b0);
        3:       run_frame(8'($urandom), 8'($urandom), opb,
                           $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        4:       abort_frame($urandom_range(1, 2), $urandom_range(0, 3));
        default: reset_mid(1'($urandom_range(0, 1)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
